// File: rtl/xif_pkg.sv
// Shared types for the CORE-V-XIF issue initiator: FSM states, issue request,
// result and ID-table entry records.
package xif_pkg;

  localparam int unsigned IdWidthDef        = 4;
  localparam int unsigned XlenDef           = 32;
  localparam int unsigned NumRsDef          = 2;
  localparam int unsigned MaxOutstandingDef = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCommit
  } state_e;

  typedef struct packed {
    logic [31:0]                  instr;
    logic [IdWidthDef-1:0]        id;
    logic [NumRsDef*XlenDef-1:0]  rs;
  } issue_req_t;

  typedef struct packed {
    logic [IdWidthDef-1:0] id;
    logic [XlenDef-1:0]    data;
    logic [4:0]            rd;
    logic                  we;
  } result_t;

  typedef struct packed {
    logic                  valid;
    logic [IdWidthDef-1:0] id;
  } tbl_entry_t;

endpackage

// File: rtl/xif_id_table.sv
// Outstanding-result tracker: allocates IDs into free slots, frees by ID from the
// result and kill paths, and reports lookup hits and the live entry count.
module xif_id_table
  import xif_pkg::*;
#(
  parameter int unsigned Entries  = MaxOutstandingDef,
  parameter int unsigned IdWidth  = IdWidthDef,
  parameter int unsigned CntWidth = $clog2(Entries + 1)
) (
  input  logic                ck,
  input  logic                rst,
  input  logic                alloc,
  input  logic [IdWidth-1:0]  alloc_id,
  input  logic                free_res,
  input  logic [IdWidth-1:0]  free_res_id,
  input  logic                free_kill,
  input  logic [IdWidth-1:0]  free_kill_id,
  input  logic [IdWidth-1:0]  lookup_id,
  output logic                lookup_hit,
  input  logic [IdWidth-1:0]  probe_id,
  output logic                probe_hit,
  output logic [CntWidth-1:0] count
);

  localparam int unsigned IdxWidth = (Entries > 1) ? $clog2(Entries) : 1;

  tbl_entry_t          entry_q [Entries];
  tbl_entry_t          entry_d [Entries];
  logic [IdxWidth-1:0] free_idx;
  logic                free_found;

  always_comb begin
    entry_d    = entry_q;
    lookup_hit = 1'b0;
    probe_hit  = 1'b0;
    count      = '0;
    free_idx   = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < Entries; i++) begin
      if (entry_q[i].valid) begin
        count = count + 1'b1;
        if (entry_q[i].id == lookup_id) lookup_hit = 1'b1;
        if (entry_q[i].id == probe_id) probe_hit = 1'b1;
        if ((free_res && (entry_q[i].id == free_res_id)) ||
            (free_kill && (entry_q[i].id == free_kill_id))) begin
          entry_d[i].valid = 1'b0;
        end
      end else if (!free_found) begin
        // Only currently empty slots qualify, so a slot freed this cycle is never reused.
        free_found = 1'b1;
        free_idx   = IdxWidth'(i);
      end
    end
    if (alloc && free_found) begin
      entry_d[free_idx].valid = 1'b1;
      entry_d[free_idx].id    = alloc_id;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      for (int unsigned i = 0; i < Entries; i++) entry_q[i] <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/xif_issue_initiator.sv
// Core-side CORE-V-XIF initiator: issues one offload at a time, commits or kills it,
// and forwards coprocessor results to the register-file writeback port.
module xif_issue_initiator
  import xif_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH      = IdWidthDef,
  parameter int unsigned XLEN            = XlenDef,
  parameter int unsigned X_NUM_RS        = NumRsDef,
  parameter int unsigned MAX_OUTSTANDING = MaxOutstandingDef
) (
  input  logic                     ck,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_instr,
  input  logic [X_NUM_RS*XLEN-1:0] req_rs,
  input  logic                     flush,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [31:0]              issue_req_instr,
  output logic [X_ID_WIDTH-1:0]    issue_req_id,
  output logic [X_NUM_RS*XLEN-1:0] issue_req_rs,
  input  logic                     issue_resp_accept,
  input  logic                     issue_resp_writeback,
  output logic                     commit_valid,
  output logic [X_ID_WIDTH-1:0]    commit_id,
  output logic                     commit_kill,
  input  logic                     result_valid,
  output logic                     result_ready,
  input  logic [X_ID_WIDTH-1:0]    result_id,
  input  logic [XLEN-1:0]          result_data,
  input  logic [4:0]               result_rd,
  input  logic                     result_we,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [X_ID_WIDTH-1:0]    wb_id,
  output logic [4:0]               wb_rd,
  output logic [XLEN-1:0]          wb_data,
  output logic                     wb_we,
  output logic                     illegal_instr,
  output logic                     protocol_err
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  state_e                state_q, state_d;
  issue_req_t            req_q, req_d;
  logic [X_ID_WIDTH-1:0] next_id_q, next_id_d;
  result_t               wb_q, wb_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  illegal_q, illegal_d;
  logic                  perr_q, perr_d;

  logic            alloc;
  logic            lookup_hit;
  logic            probe_hit;
  logic [CntW-1:0] count;
  logic            req_hs;
  logic            result_hs;

  xif_id_table #(
    .Entries (MAX_OUTSTANDING),
    .IdWidth (X_ID_WIDTH),
    .CntWidth(CntW)
  ) u_id_table (
    .ck          (ck),
    .rst         (rst),
    .alloc       (alloc),
    .alloc_id    (req_q.id),
    .free_res    (result_hs),
    .free_res_id (result_id),
    .free_kill   (commit_kill),
    .free_kill_id(req_q.id),
    .lookup_id   (result_id),
    .lookup_hit  (lookup_hit),
    .probe_id    (next_id_q),
    .probe_hit   (probe_hit),
    .count       (count)
  );

  // Ready outputs are gated by rst so they read 0 while reset is held.
  assign req_ready    = !rst && (state_q == StIdle) && (count < CntW'(MAX_OUTSTANDING)) &&
                        !probe_hit;
  assign result_ready = !rst && (!wb_valid_q || wb_ready);
  assign req_hs       = req_valid && req_ready;
  assign result_hs    = result_valid && result_ready;

  assign issue_valid     = (state_q == StIssue);
  assign issue_req_instr = req_q.instr;
  assign issue_req_id    = req_q.id;
  assign issue_req_rs    = req_q.rs;

  assign commit_valid = (state_q == StCommit);
  assign commit_id    = req_q.id;
  assign commit_kill  = commit_valid && flush;

  assign wb_valid      = wb_valid_q;
  assign wb_id         = wb_q.id;
  assign wb_rd         = wb_q.rd;
  assign wb_data       = wb_q.data;
  assign wb_we         = wb_q.we;
  assign illegal_instr = illegal_q;
  assign protocol_err  = perr_q;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    next_id_d = next_id_q;
    alloc     = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_hs) begin
          req_d.instr = req_instr;
          req_d.rs    = req_rs;
          req_d.id    = next_id_q;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (issue_ready) begin
          if (issue_resp_accept) begin
            alloc     = issue_resp_writeback;
            next_id_d = next_id_q + 1'b1;
            state_d   = StCommit;
          end else begin
            illegal_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    wb_valid_d = wb_valid_q && !wb_ready;
    wb_d       = wb_q;
    perr_d     = 1'b0;
    if (result_hs) begin
      if (lookup_hit) begin
        wb_valid_d = 1'b1;
        wb_d       = '{id: result_id, data: result_data, rd: result_rd, we: result_we};
      end else begin
        perr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q    <= StIdle;
      req_q      <= '0;
      next_id_q  <= '0;
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      next_id_q  <= next_id_d;
      wb_q       <= wb_d;
      wb_valid_q <= wb_valid_d;
      illegal_q  <= illegal_d;
      perr_q     <= perr_d;
    end
  end

endmodule

// File: tb/tb_xif_issue_initiator.sv
// Scoreboard bench for xif_issue_initiator: directed scenarios followed by random traffic,
// checked against a transaction-level model of outstanding IDs.
module tb_xif_issue_initiator;

  logic        ck, rst;
  logic        req_valid, req_ready;
  logic [31:0] req_instr;
  logic [63:0] req_rs;
  logic        flush;
  logic        issue_valid, issue_ready;
  logic [31:0] issue_req_instr;
  logic [3:0]  issue_req_id;
  logic [63:0] issue_req_rs;
  logic        issue_resp_accept, issue_resp_writeback;
  logic        commit_valid, commit_kill;
  logic [3:0]  commit_id;
  logic        result_valid, result_ready;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic        result_we;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_id;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_we;
  logic        illegal_instr, protocol_err;

  xif_issue_initiator dut (
    .ck                  (ck),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_instr           (req_instr),
    .req_rs              (req_rs),
    .flush               (flush),
    .issue_valid         (issue_valid),
    .issue_ready         (issue_ready),
    .issue_req_instr     (issue_req_instr),
    .issue_req_id        (issue_req_id),
    .issue_req_rs        (issue_req_rs),
    .issue_resp_accept   (issue_resp_accept),
    .issue_resp_writeback(issue_resp_writeback),
    .commit_valid        (commit_valid),
    .commit_id           (commit_id),
    .commit_kill         (commit_kill),
    .result_valid        (result_valid),
    .result_ready        (result_ready),
    .result_id           (result_id),
    .result_data         (result_data),
    .result_rd           (result_rd),
    .result_we           (result_we),
    .wb_valid            (wb_valid),
    .wb_ready            (wb_ready),
    .wb_id               (wb_id),
    .wb_rd               (wb_rd),
    .wb_data             (wb_data),
    .wb_we               (wb_we),
    .illegal_instr       (illegal_instr),
    .protocol_err        (protocol_err)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  typedef struct {
    logic [31:0] instr;
    logic [63:0] rs;
  } req_s;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } wb_s;

  int   checks = 0;
  int   failures = 0;
  bit   outstanding [16];
  int   next_id, phase, commit_exp;  // phase: 0 waiting for request, 1 issuing, 2 committing
  bit   exp_illegal, exp_perr;
  req_s reqq[$];
  wb_s  wbq[$];
  wb_s  mon_wb;
  bit   req_hs, res_hs, rst_prev, drv_timeout;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int n_outstanding();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(outstanding[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) outstanding[i] = 1'b0;
    next_id = 0;
    phase = 0;
    commit_exp = 0;
    exp_illegal = 1'b0;
    exp_perr = 1'b0;
    reqq.delete();
    wbq.delete();
    req_hs = 1'b0;
    res_hs = 1'b0;
  endtask

  // Monitor: compares DUT outputs to the model each cycle, then advances the model
  // with the handshakes that will complete at the coming rising edge.
  always @(negedge ck) begin
    if (rst) begin
      if (rst_prev) begin
        chk("rst_ctrl", {56'd0, req_ready, issue_valid, commit_valid, commit_kill, result_ready,
                         wb_valid, illegal_instr, protocol_err}, 64'd0);
        chk("rst_issue_bus", {28'd0, issue_req_id, issue_req_instr}, 64'd0);
        chk("rst_issue_rs", issue_req_rs, 64'd0);
        chk("rst_wb_bus", {18'd0, commit_id, wb_id, wb_rd, wb_we, wb_data}, 64'd0);
      end
      model_reset();
    end else begin
      chk("drv_timeout", drv_timeout, 1'b0);
      chk("illegal_instr", illegal_instr, exp_illegal);
      chk("protocol_err", protocol_err, exp_perr);
      chk("issue_valid", issue_valid, phase == 1);
      chk("commit_valid", commit_valid, phase == 2);
      chk("req_ready", req_ready, (phase == 0) && (n_outstanding() < 4) && !outstanding[next_id]);
      chk("wb_valid", wb_valid, wbq.size() != 0);
      chk("result_ready", result_ready, (wbq.size() == 0) || wb_ready);
      if (phase == 1 && reqq.size() != 0) begin
        chk("issue_instr", issue_req_instr, reqq[0].instr);
        chk("issue_rs", issue_req_rs, reqq[0].rs);
        chk("issue_id", issue_req_id, 64'(next_id));
      end
      if (phase == 2) begin
        chk("commit_id", commit_id, 64'(commit_exp));
        chk("commit_kill", commit_kill, flush);
      end
      if (wbq.size() != 0 && wb_ready) begin
        mon_wb = wbq.pop_front();
        chk("wb_id", wb_id, mon_wb.id);
        chk("wb_rd", wb_rd, mon_wb.rd);
        chk("wb_data", wb_data, mon_wb.data);
        chk("wb_we", wb_we, mon_wb.we);
      end

      exp_illegal = 1'b0;
      exp_perr = 1'b0;
      res_hs = result_valid && result_ready;
      req_hs = (phase == 0) && req_valid && req_ready;
      // Result lookup sees the table as it stood before this cycle's allocate/kill.
      if (res_hs) begin
        if (outstanding[result_id]) begin
          wbq.push_back('{id: result_id, rd: result_rd, data: result_data, we: result_we});
          outstanding[result_id] = 1'b0;
        end else begin
          exp_perr = 1'b1;
        end
      end
      case (phase)
        0: if (req_hs) begin
          reqq.push_back('{instr: req_instr, rs: req_rs});
          phase = 1;
        end
        1: if (issue_ready) begin
          if (reqq.size() != 0) void'(reqq.pop_front());
          if (issue_resp_accept) begin
            if (issue_resp_writeback) outstanding[next_id] = 1'b1;
            commit_exp = next_id;
            next_id = (next_id + 1) % 16;
            phase = 2;
          end else begin
            exp_illegal = 1'b1;
            phase = 0;
          end
        end
        default: begin
          if (flush) outstanding[commit_exp] = 1'b0;
          phase = 0;
        end
      endcase
    end
    rst_prev = rst;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge ck);
      #1;
    end
  endtask

  task automatic send_req(input logic [31:0] ins, input logic [63:0] rs);
    bit done = 1'b0;
    req_valid = 1'b1;
    req_instr = ins;
    req_rs = rs;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge ck);
      #1;
      done = req_hs;
    end
    if (!done) drv_timeout = 1'b1;
    req_valid = 1'b0;
  endtask

  task automatic send_result(input logic [3:0] id, input logic [4:0] rd, input logic [31:0] data,
                             input logic we);
    bit done = 1'b0;
    result_valid = 1'b1;
    result_id = id;
    result_rd = rd;
    result_data = data;
    result_we = we;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge ck);
      #1;
      done = res_hs;
    end
    if (!done) drv_timeout = 1'b1;
    result_valid = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int ids[$];
    rst = 1'b1;
    req_valid = 1'b0; req_instr = '0; req_rs = '0; flush = 1'b0;
    issue_ready = 1'b0; issue_resp_accept = 1'b0; issue_resp_writeback = 1'b0;
    result_valid = 1'b0; result_id = '0; result_data = '0; result_rd = '0; result_we = 1'b0;
    wb_ready = 1'b0; drv_timeout = 1'b0;
    model_reset();
    step(3);
    rst = 1'b0;
    step(1);

    // Basic flow
    issue_ready = 1'b1; issue_resp_accept = 1'b1; issue_resp_writeback = 1'b1; wb_ready = 1'b1;
    send_req(32'h00A5_7053, 64'h0000_0000_0000_1234);
    step(3);
    send_result(4'd0, 5'd5, 32'hDEAD_BEEF, 1'b1);
    step(2);

    // Reject, then a reissue reuses the same ID
    issue_resp_accept = 1'b0;
    send_req(32'h0000_0053, rnd64());
    step(3);
    issue_resp_accept = 1'b1; issue_resp_writeback = 1'b0;
    send_req(32'h0010_0053, rnd64());
    step(3);

    // Stall: issue_ready low for 5 cycles
    issue_ready = 1'b0;
    send_req(32'h0220_0053, rnd64());
    step(5);
    issue_ready = 1'b1;
    step(3);

    // Kill: flush held through ISSUE and COMMIT, then a late result for the killed ID
    issue_resp_writeback = 1'b1; flush = 1'b1;
    send_req(32'h0330_0053, rnd64());
    step(2);
    flush = 1'b0;
    step(1);
    send_result(4'd3, 5'd7, 32'h1111_2222, 1'b1);
    step(2);

    // Reset in the middle of an issue
    issue_ready = 1'b0;
    send_req(32'h0440_0053, rnd64());
    step(2);
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
    issue_ready = 1'b1;

    // Full, reopen, wrap with ID 0 still outstanding
    issue_resp_writeback = 1'b1;
    repeat (4) send_req($urandom(), rnd64());
    step(4);
    send_result(4'd1, 5'd1, 32'hA5A5_0001, 1'b1);
    step(2);
    issue_resp_writeback = 1'b0;
    repeat (12) send_req($urandom(), rnd64());
    step(4);
    send_result(4'd0, 5'd2, 32'hA5A5_0000, 1'b1);
    step(2);
    send_result(4'd2, 5'd3, 32'hA5A5_0002, 1'b0);
    send_result(4'd3, 5'd4, 32'hA5A5_0003, 1'b1);
    step(2);

    // Result handshake in the same cycle as an accepted issue
    issue_resp_writeback = 1'b1;
    send_req($urandom(), rnd64());
    step(3);
    issue_ready = 1'b0;
    send_req($urandom(), rnd64());
    result_valid = 1'b1; result_id = 4'd0; result_rd = 5'd9; result_data = 32'hCAFE_0000;
    result_we = 1'b1; issue_ready = 1'b1;
    step(1);
    result_valid = 1'b0;
    step(3);
    send_result(4'd1, 5'd10, 32'hCAFE_0001, 1'b1);
    step(2);

    // Random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (req_hs) req_valid = 1'b0;
      if (!req_valid && $urandom_range(2) == 0) begin
        req_valid = 1'b1;
        req_instr = $urandom();
        req_rs = rnd64();
      end
      if (res_hs) result_valid = 1'b0;
      if (!result_valid && $urandom_range(2) == 0) begin
        ids.delete();
        for (int i = 0; i < 16; i++) if (outstanding[i]) ids.push_back(i);
        result_valid = 1'b1;
        if (ids.size() != 0 && $urandom_range(3) != 0)
          result_id = 4'(ids[$urandom_range(ids.size() - 1)]);
        else
          result_id = 4'($urandom_range(15));
        result_rd = 5'($urandom());
        result_data = $urandom();
        result_we = 1'($urandom());
      end
      issue_ready = ($urandom_range(2) != 0);
      issue_resp_accept = ($urandom_range(9) != 0);
      issue_resp_writeback = ($urandom_range(9) < 7);
      flush = ($urandom_range(4) == 0);
      wb_ready = ($urandom_range(9) < 7);
      step(1);
    end

    req_valid = 1'b0; result_valid = 1'b0; flush = 1'b0;
    issue_ready = 1'b1; wb_ready = 1'b1;
    step(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
